// File: rtl/add_share_pkg.sv
// Shared definitions for the add-share arbiter: result-register FSM encoding.
package add_share_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;
endpackage

// File: rtl/cla_adder.sv
// N-bit carry-lookahead adder: every carry is a flat sum-of-products of
// generate/propagate terms rather than a ripple chain.
module cla_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;
  logic         term;
  logic         acc;

  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry    = '0;
    carry[0] = cin_i;
    term     = 1'b0;
    acc      = 1'b0;
    for (int i = 0; i < N; i++) begin
      // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) term = term & prop[k];
        acc = acc | term;
      end
      term = cin_i;
      for (int k = 0; k <= i; k++) term = term & prop[k];
      carry[i+1] = acc | term;
    end
  end

  assign sum_o  = prop ^ carry[N-1:0];
  assign cout_o = carry[N];
endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one carry-lookahead adder among R requesters,
// with a single registered result slot that supports back-to-back issue.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_x,
  input  logic [R*N-1:0] req_y,
  input  logic [R-1:0]   req_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout
);
  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           can_accept;
  logic           hs;
  logic [N-1:0]   op_x, op_y, sum_w;
  logic           op_cin, cout_w;
  logic [N-1:0]   rsp_sum_q;
  logic           rsp_cout_q;
  logic [IDW-1:0] rsp_id_q;

  // First valid requester at or after rr_ptr, wrapping past R-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < R; k++) begin
      automatic int cand = (int'(rr_ptr_q) + k) % R;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  assign can_accept = (state_q == IDLE) | rsp_ready;

  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign hs     = |req_ready;
  assign op_x   = req_x[grant_idx*N +: N];
  assign op_y   = req_y[grant_idx*N +: N];
  assign op_cin = req_cin[grant_idx];

  cla_adder #(.N(N)) u_cla (
    .a_i   (op_x),
    .b_i   (op_y),
    .cin_i (op_cin),
    .sum_o (sum_w),
    .cout_o(cout_w)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (grant_idx == IDW'(R - 1)) ? '0 : grant_idx + 1'b1;
    case (state_q)
      IDLE:    if (hs) state_d = HOLD;
      HOLD:    if (rsp_ready && !hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (hs) begin
        rsp_sum_q  <= sum_w;
        rsp_cout_q <= cout_w;
        rsp_id_q   <= grant_idx;
      end
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed scenarios plus a long
// randomized run against a queue-based reference model.
module tb_add_share_arb;
  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [R-1:0] req_valid = '0;
  logic [R-1:0] req_ready;
  logic [R*N-1:0] req_x = '0;
  logic [R*N-1:0] req_y = '0;
  logic [R-1:0] req_cin = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [N-1:0] rsp_sum;
  logic         rsp_cout;

  int checks = 0;
  int errors = 0;

  add_share_arb #(.N(N), .R(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input int x, input int y, input bit cin);
    req_x[idx*N +: N] = N'(x);
    req_y[idx*N +: N] = N'(y);
    req_cin[idx]      = cin;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    step();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_cout, rsp_sum, rsp_id} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b cout=%b sum=%0d id=%0d expected all 0",
               rsp_valid, rsp_cout, rsp_sum, rsp_id);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    set_op(2, 5, 9, 1'b0);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b expected 0100", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 4'd14 || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_result: got valid=%b sum=%0d cout=%b id=%0d expected 1/14/0/2",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got valid=%b expected 0", rsp_valid);
    end
    rsp_ready = 1'b0;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int xs[R], ys[R];
    do_reset();
    for (int i = 0; i < R; i++) begin
      xs[i] = $urandom_range(0, 15);
      ys[i] = $urandom_range(0, 15);
      set_op(i, xs[i], ys[i], 1'b0);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int s;
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_g[k])) begin
        errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'(1 << exp_g[k]));
      end
      step();
      s = xs[exp_g[k]] + ys[exp_g[k]];
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[k]) || rsp_sum !== 4'(s) || rsp_cout !== s[4]) begin
        errors++;
        $display("FAIL rr_result%0d: got valid=%b id=%0d sum=%0d cout=%b expected 1/%0d/%0d/%b",
                 k, rsp_valid, rsp_id, rsp_sum, rsp_cout, exp_g[k], s & 15, s[4]);
      end
      $display("rr cycle %0d: grant %0d sum %0d", k, exp_g[k], rsp_sum);
    end
    req_valid = '0;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow();
    set_op(3, 15, 15, 1'b1);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 4'd15 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL overflow: got valid=%b sum=%0d cout=%b id=%0d expected 1/15/1/3",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("test_overflow done");
  endtask

  task automatic test_backpressure();
    set_op(1, 6, 7, 1'b1);
    req_valid = 4'b0010;
    step();
    set_op(1, 3, 4, 1'b0);
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready%0d: got %b expected 0000", k, req_ready);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 4'd14 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
        errors++;
        $display("FAIL bp_stable%0d: got valid=%b sum=%0d cout=%b id=%0d expected 1/14/0/1",
                 k, rsp_valid, rsp_sum, rsp_cout, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 4'd7 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL bp_new_result: got valid=%b sum=%0d cout=%b id=%0d expected 1/7/0/1",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    step();
    rsp_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    set_op(0, 1, 2, 1'b0);
    set_op(3, 4, 4, 1'b0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL midhold_reset: got valid=%b ready=%b expected 0/0000", rsp_valid, req_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midhold_regrant: got %b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 4'd3) begin
      errors++;
      $display("FAIL midhold_result: got valid=%b id=%0d sum=%0d expected 1/0/3",
               rsp_valid, rsp_id, rsp_sum);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_random();
    int q_id[$], q_sum[$], q_cout[$];
    int ptr = 0;
    int wait_cnt[R] = '{default: 0};
    int last_g = -1;
    int accepted = 0, produced = 0;
    localparam int CYC = 10000;
    do_reset();
    req_valid = '0;
    for (int cyc = 0; cyc < CYC + 3; cyc++) begin
      int g;
      bit can;
      logic [R-1:0] exp_rdy;
      if (cyc < CYC) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < R; i++) begin
          if (req_valid[i] && i != last_g) req_valid[i] = ($urandom_range(0, 7) != 0);
          else req_valid[i] = ($urandom_range(0, 1) != 0);
          set_op(i, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      #1;
      g = -1;
      for (int k = 0; k < R; k++)
        if (g < 0 && req_valid[(ptr + k) % R]) g = (ptr + k) % R;
      can     = (q_id.size() == 0) || rsp_ready;
      exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_rdy);
      end
      checks++;
      if (rsp_valid !== (q_id.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d: got %b expected %b", cyc, rsp_valid, q_id.size() != 0);
      end
      if (q_id.size() != 0 && rsp_ready) begin
        checks++;
        if (rsp_id !== 2'(q_id[0]) || rsp_sum !== 4'(q_sum[0]) || rsp_cout !== q_cout[0][0]) begin
          errors++;
          $display("FAIL rnd_result cyc %0d: got id=%0d sum=%0d cout=%b expected %0d/%0d/%0d",
                   cyc, rsp_id, rsp_sum, rsp_cout, q_id[0], q_sum[0], q_cout[0]);
        end
        void'(q_id.pop_front()); void'(q_sum.pop_front()); void'(q_cout.pop_front());
        produced++;
      end
      if (exp_rdy != 0) begin
        int s = int'(req_x[g*N +: N]) + int'(req_y[g*N +: N]) + int'(req_cin[g]);
        q_id.push_back(g);
        q_sum.push_back(s % 16);
        q_cout.push_back(s / 16);
        accepted++;
        ptr = (g + 1) % R;
        for (int i = 0; i < R; i++) begin
          if (i == g || !req_valid[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > R - 1) begin
              errors++;
              $display("FAIL rnd_starve cyc %0d: req %0d waited %0d grants, limit %0d",
                       cyc, i, wait_cnt[i], R - 1);
            end
          end
        end
        last_g = g;
      end else begin
        for (int i = 0; i < R; i++) if (!req_valid[i]) wait_cnt[i] = 0;
        last_g = -1;
      end
      step();
    end
    checks++;
    if (produced !== accepted || q_id.size() != 0) begin
      errors++;
      $display("FAIL rnd_count: got %0d results expected %0d (pending %0d)",
               produced, accepted, q_id.size());
    end
    $display("test_random done: %0d accepted, %0d results", accepted, produced);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_share_arb.md
ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 SHALL have parameter N, default 4: operand width in bits (N >= 1).
REQ-002 SHALL have parameter R, default 4: number of requesters (R >= 2); IDW = $clog2(R).
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, R: per-requester request valid.
REQ-006 SHALL have port req_ready, output, R: per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_x, input, R*N: requester i operand x at bits [i*N +: N].
REQ-008 SHALL have port req_y, input, R*N: requester i operand y at bits [i*N +: N].
REQ-009 SHALL have port req_cin, input, R: requester i carry-in.
REQ-010 SHALL have port rsp_valid, output, 1: result register holds a valid result.
REQ-011 SHALL have port rsp_ready, input, 1: downstream accepts the result.
REQ-012 SHALL have port rsp_id, output, IDW: index of the requester that owns the result.
REQ-013 SHALL have port rsp_sum, output, N: registered sum.
REQ-014 SHALL have port rsp_cout, output, 1: registered carry-out.

Function
REQ-015 SHALL share one N-bit carry-lookahead adder among all R requesters; only the granted requester's x, y, cin drive it.
REQ-016 SHALL implement FSM states IDLE (result register empty) and HOLD (result register full).
REQ-017 SHALL define can_accept = (state==IDLE) | rsp_ready.
REQ-018 SHALL grant round-robin: the first valid requester at or after rr_ptr, ascending, wrapping at R-1 -> 0.
REQ-019 SHALL drive req_ready[g] = can_accept & req_valid[g] for the granted g only; all other bits 0; combinational.
REQ-020 SHALL, on a handshake (req_valid[g] & req_ready[g]), load rsp_sum/rsp_cout = x+y+cin of g (cout = bit N) and rsp_id = g on the same edge; latency 1 cycle.
REQ-021 SHALL, on a handshake, set rr_ptr <= (g+1) mod R; rr_ptr unchanged otherwise.
REQ-022 SHALL transition IDLE->HOLD on a handshake; HOLD->IDLE on rsp_ready with no handshake; HOLD->HOLD on rsp_ready with handshake (back-to-back, one result per cycle) or on !rsp_ready.
REQ-023 SHALL hold rsp_sum, rsp_cout, rsp_id stable while rsp_valid & !rsp_ready.
REQ-024 SHALL assert rsp_valid exactly when state==HOLD.
REQ-025 SHALL issue no grant when req_valid == 0; state/pointer unchanged except drain per REQ-022.
REQ-026 SHALL treat operand all-ones + all-ones + cin=1 as sum = all-ones, cout = 1 (full-width wrap).
REQ-027 SHALL not require requesters to hold req_valid; a deasserted request loses nothing already accepted.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set state=IDLE, rr_ptr=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
REQ-029 SHALL force req_ready=0 while rst_n is low; a result held mid-operation is discarded.
REQ-030 SHALL resume arbitration from requester 0 on the first edge after rst_n deasserts.

Structure
REQ-031 SHALL instantiate cla_adder (parameter N) as the single shared sub-module; no other adder.
REQ-032 SHALL place the FSM state encoding (IDLE, HOLD) in a shared package add_share_pkg; N and R remain module parameters.

Verification
REQ-033 SHALL cover: reset, N=4, req 2 only, x=5,y=9,cin=0 -> one cycle later rsp_valid=1, rsp_sum=14, rsp_cout=0, rsp_id=2.
REQ-034 SHALL cover: all 4 req_valid held, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_id follows 1 cycle later.
REQ-035 SHALL cover: x=15,y=15,cin=1 -> rsp_sum=15, rsp_cout=1.
REQ-036 SHALL cover: rsp_ready=0 for 3 cycles with req 1 valid -> req_ready=0, rsp fields stable; rsp_ready=1 -> req 1 granted same cycle, new result next cycle.
REQ-037 SHALL cover: rst_n pulled low while HOLD -> rsp_valid=0 immediately, next grant after release goes to lowest valid index from 0.
REQ-038 SHALL cover: random req_valid/rsp_ready over 10k cycles -> every accepted request produces exactly one result with correct sum and id, no requester starved beyond R-1 grants.
